mmu_dma_responder: RTL and testbench

MMU-side responder for the OAM DMA request bus. It services the byte read/write requests issued by the DMA initiator over `DMA_if` and arbitrates the single downstream memory port between DMA and CPU. While a transfer is in flight, it locks the CPU out of everything except HRAM, posts blocked HRAM writes, and reports completion and protocol errors. It sits inside the MMU, between the CPU `Bus_if`, the DMA engine, and the memory decode.

---
 rtl/mmu_addresses_pkg.sv | 22 ++
 rtl/mmu_dma_responder_if.sv | 41 ++++
 rtl/mmu_dma_responder_posted_write_buf.sv | 28 ++
 rtl/mmu_dma_responder.sv | 117 +++++++++++
 tb/tb_mmu_dma_responder.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mmu_addresses_pkg.sv
// MMU address map constants and shared types for the DMA responder slice.
package mmu_addresses_pkg;

   localparam logic [15:0] OAM_start   = 16'hFE00;
   localparam logic [15:0] HRAM_start  = 16'hFF80;
   localparam logic [15:0] HRAM_end    = 16'hFFFE;
   localparam int unsigned OAM_DMA_LEN = 160;
   localparam logic [15:0] OAM_end     = OAM_start + 16'(OAM_DMA_LEN - 1);

   typedef enum logic [1:0] {
      IDLE,
      LOCK,
      RELEASE
   } dma_arb_state_t;

   function automatic logic in_range(input logic [15:0] a,
                                     input logic [15:0] lo,
                                     input logic [15:0] hi);
      return (a >= lo) && (a <= hi);
   endfunction

endpackage

// File: rtl/mmu_dma_responder_if.sv
// DMA request, CPU request and downstream memory port bundle seen by the responder.
interface mmu_dma_responder_if;

   logic        dma_active;
   logic [15:0] dma_addr;
   logic        dma_read_en;
   logic        dma_write_en;
   logic [7:0]  dma_wdata;
   logic [7:0]  dma_rdata;

   logic [15:0] cpu_addr;
   logic        cpu_read_en;
   logic        cpu_write_en;
   logic [7:0]  cpu_wdata;
   logic [7:0]  cpu_rdata;

   logic [15:0] mem_addr;
   logic        mem_read_en;
   logic        mem_write_en;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;

   modport slave (
      input  dma_active, dma_addr, dma_read_en, dma_write_en, dma_wdata,
      output dma_rdata,
      input  cpu_addr, cpu_read_en, cpu_write_en, cpu_wdata,
      output cpu_rdata,
      output mem_addr, mem_read_en, mem_write_en, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output dma_active, dma_addr, dma_read_en, dma_write_en, dma_wdata,
      input  dma_rdata,
      output cpu_addr, cpu_read_en, cpu_write_en, cpu_wdata,
      input  cpu_rdata,
      input  mem_addr, mem_read_en, mem_write_en, mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/mmu_dma_responder_posted_write_buf.sv
// One-entry holding register for a CPU HRAM write that collided with a DMA cycle.
module posted_write_buf (
   input  logic        clk,
   input  logic        reset,
   input  logic        push,
   input  logic        pop,
   input  logic [15:0] addr_in,
   input  logic [7:0]  data_in,
   output logic        full,
   output logic [15:0] addr,
   output logic [7:0]  data
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         full <= 1'b0;
         addr <= '0;
         data <= '0;
      end else if (push) begin
         full <= 1'b1;
         addr <= addr_in;
         data <= data_in;
      end else if (pop) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/mmu_dma_responder.sv
// OAM DMA responder: arbitrates the memory port between DMA and CPU, locks the
// CPU out to HRAM during a transfer, posts colliding HRAM writes, tracks OAM progress.
module mmu_dma_responder
   import mmu_addresses_pkg::*;
(
   input  logic                       clk,
   input  logic                       reset,
   mmu_dma_responder_if.slave         bus,
   output logic [7:0]                 oam_count,
   output logic                       dma_done,
   output logic [15:0]                cpu_blocked,
   output logic                       dma_err
);

   dma_arb_state_t state;

   logic        dma_owns, dma_req, cpu_acc, cpu_hram, dma_in_oam;
   logic        oam_hit, oam_full, oam_wr, enter_lock, cpu_reject;
   logic        pw_push, pw_pop, pw_full;
   logic [15:0] pw_addr;
   logic [7:0]  pw_data;

   assign dma_owns   = bus.dma_active || (state != IDLE);
   assign dma_req    = bus.dma_read_en || bus.dma_write_en;
   assign cpu_acc    = bus.cpu_read_en || bus.cpu_write_en;
   assign cpu_hram   = in_range(bus.cpu_addr, HRAM_start, HRAM_end);
   assign dma_in_oam = in_range(bus.dma_addr, OAM_start, OAM_end);
   assign enter_lock = (state == IDLE) && bus.dma_active;

   assign oam_hit  = bus.dma_write_en && dma_in_oam;
   assign oam_full = (oam_count == 8'(OAM_DMA_LEN));
   assign oam_wr   = oam_hit && !oam_full;

   assign cpu_reject = dma_owns && cpu_acc &&
                       (!cpu_hram || (dma_req && (!bus.cpu_write_en || pw_full)));
   assign pw_push    = dma_owns && bus.cpu_write_en && cpu_hram && dma_req && !pw_full;
   assign pw_pop     = pw_full && !dma_req && !cpu_acc;

   posted_write_buf u_pw (
      .clk     (clk),
      .reset   (reset),
      .push    (pw_push),
      .pop     (pw_pop),
      .addr_in (bus.cpu_addr),
      .data_in (bus.cpu_wdata),
      .full    (pw_full),
      .addr    (pw_addr),
      .data    (pw_data)
   );

   // Port priority: DMA request, then CPU (only when allowed through), then flush.
   always_comb begin
      bus.mem_addr     = bus.cpu_addr;
      bus.mem_wdata    = bus.cpu_wdata;
      bus.mem_read_en  = 1'b0;
      bus.mem_write_en = 1'b0;
      bus.cpu_rdata    = 8'hFF;
      bus.dma_rdata    = bus.mem_rdata;
      if (dma_req) begin
         bus.mem_addr     = bus.dma_addr;
         bus.mem_wdata    = bus.dma_wdata;
         bus.mem_read_en  = bus.dma_read_en;
         bus.mem_write_en = bus.dma_write_en;
      end else if (cpu_acc) begin
         if (!dma_owns || cpu_hram) begin
            bus.mem_read_en  = bus.cpu_read_en;
            bus.mem_write_en = bus.cpu_write_en;
         end
      end else if (pw_full) begin
         bus.mem_addr     = pw_addr;
         bus.mem_wdata    = pw_data;
         bus.mem_write_en = 1'b1;
      end
      if (!dma_owns || (cpu_hram && !dma_req))
         bus.cpu_rdata = bus.mem_rdata;
      if (reset) begin
         bus.mem_read_en  = 1'b0;
         bus.mem_write_en = 1'b0;
         bus.cpu_rdata    = '0;
         bus.dma_rdata    = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         oam_count   <= '0;
         dma_done    <= 1'b0;
         cpu_blocked <= '0;
         dma_err     <= 1'b0;
      end else begin
         case (state)
            IDLE:    if (bus.dma_active) state <= LOCK;
            LOCK:    if (!bus.dma_active) state <= RELEASE;
            RELEASE: state <= bus.dma_active ? LOCK : IDLE;
            default: state <= IDLE;
         endcase

         // A write landing in the same cycle the transfer starts is the first byte.
         if (enter_lock)
            oam_count <= oam_hit ? 8'd1 : '0;
         else if (oam_wr)
            oam_count <= oam_count + 8'd1;

         dma_done <= oam_wr && !enter_lock && (oam_count == 8'(OAM_DMA_LEN - 1));

         if (cpu_reject && (cpu_blocked != '1))
            cpu_blocked <= cpu_blocked + 16'd1;

         if ((dma_req && !dma_owns) ||
             (bus.dma_read_en && bus.dma_write_en) ||
             (bus.dma_write_en && (!dma_in_oam || (oam_full && !enter_lock))))
            dma_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mmu_dma_responder.sv
// Self-checking bench for mmu_dma_responder: vector table, OAM transfer scoreboard, corner sequences.
module tb_mmu_dma_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  oam_count;
   logic        dma_done;
   logic [15:0] cpu_blocked;
   logic        dma_err;

   mmu_dma_responder_if bus();

   mmu_dma_responder dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .oam_count   (oam_count),
      .dma_done    (dma_done),
      .cpu_blocked (cpu_blocked),
      .dma_err     (dma_err)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] pat(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h3C;
   endfunction

   // Downstream memory: preloaded with pat() on the first edge, then written by the DUT.
   logic [7:0] mem [0:65535];
   logic       mem_ready = 1'b0;
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 65536; i++) mem[i] <= pat(16'(i));
         mem_ready <= 1'b1;
      end else if (bus.mem_write_en) begin
         mem[bus.mem_addr] <= bus.mem_wdata;
      end
   end
   assign bus.mem_rdata = mem[bus.mem_addr];

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic act, input logic [15:0] daddr, input logic drd,
                        input logic dwr, input logic [7:0] dwd, input logic [15:0] caddr,
                        input logic crd, input logic cwr, input logic [7:0] cwd);
      bus.dma_active   = act;
      bus.dma_addr     = daddr;
      bus.dma_read_en  = drd;
      bus.dma_write_en = dwr;
      bus.dma_wdata    = dwd;
      bus.cpu_addr     = caddr;
      bus.cpu_read_en  = crd;
      bus.cpu_write_en = cwr;
      bus.cpu_wdata    = cwd;
   endtask

   task automatic idle_inputs(input logic act);
      drive(act, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle_inputs(1'b0);
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   typedef struct {
      logic        act;
      logic [15:0] daddr;
      logic        drd, dwr;
      logic [7:0]  dwd;
      logic [15:0] caddr;
      logic        crd, cwr;
      logic [7:0]  cwd;
      logic [15:0] e_addr;
      logic        e_re, e_we;
      logic [7:0]  e_wd, e_crd, e_drd;
   } vec_t;

   vec_t       tbl [11];
   logic [7:0] sb [$];
   logic [7:0] rd_byte;
   logic [7:0] exp_byte;
   int         done_cnt;

   initial begin
      //          act daddr    rd wr wd     caddr    rd wr wd     e_addr   re we e_wd   e_crd  e_drd
      tbl[0]  = '{0, 16'h0000, 0, 0, 8'h00, 16'hC000, 1, 0, 8'h00, 16'hC000, 1, 0, 8'h00, 8'hFC, 8'h00};
      tbl[1]  = '{1, 16'h0000, 0, 0, 8'h00, 16'hC000, 1, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 8'hFF, 8'h00};
      tbl[2]  = '{1, 16'hC010, 1, 0, 8'h00, 16'hC000, 1, 0, 8'h00, 16'hC010, 1, 0, 8'h00, 8'hFF, 8'hEC};
      tbl[3]  = '{1, 16'hFE00, 0, 1, 8'h11, 16'hFF90, 0, 1, 8'h5A, 16'hFE00, 0, 1, 8'h11, 8'h00, 8'h00};
      tbl[4]  = '{1, 16'hC011, 1, 0, 8'h00, 16'hFF92, 0, 1, 8'h77, 16'hC011, 1, 0, 8'h00, 8'h00, 8'hED};
      tbl[5]  = '{1, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'hFF90, 0, 1, 8'h5A, 8'h00, 8'h00};
      tbl[6]  = '{1, 16'h0000, 0, 0, 8'h00, 16'hFF90, 1, 0, 8'h00, 16'hFF90, 1, 0, 8'h00, 8'h5A, 8'h00};
      tbl[7]  = '{1, 16'h0000, 0, 0, 8'h00, 16'hFF92, 1, 0, 8'h00, 16'hFF92, 1, 0, 8'h00, 8'h51, 8'h00};
      tbl[8]  = '{0, 16'h0000, 0, 0, 8'h00, 16'hC000, 1, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 8'hFF, 8'h00};
      tbl[9]  = '{0, 16'h0000, 0, 0, 8'h00, 16'hC000, 1, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 8'hFF, 8'h00};
      tbl[10] = '{0, 16'h0000, 0, 0, 8'h00, 16'hC000, 1, 0, 8'h00, 16'hC000, 1, 0, 8'h00, 8'hFC, 8'h00};

      // Reset values, with live requests present to prove the read paths are forced to 0.
      drive(1'b0, 16'hC002, 1'b1, 1'b0, 8'h00, 16'hC001, 1'b1, 1'b0, 8'h00);
      reset = 1'b1;
      repeat (3) tick();
      check("rst_mem_re", bus.mem_read_en, 1'b0);
      check("rst_mem_we", bus.mem_write_en, 1'b0);
      check("rst_cpu_rdata", bus.cpu_rdata, 8'h00);
      check("rst_dma_rdata", bus.dma_rdata, 8'h00);
      check("rst_oam_count", oam_count, 8'd0);
      check("rst_cpu_blocked", cpu_blocked, 16'd0);
      check("rst_dma_done", dma_done, 1'b0);
      check("rst_dma_err", dma_err, 1'b0);
      idle_inputs(1'b0);
      reset = 1'b0;
      tick();

      // Cycle-by-cycle arbitration vectors.
      for (int unsigned k = 0; k < 11; k++) begin
         drive(tbl[k].act, tbl[k].daddr, tbl[k].drd, tbl[k].dwr, tbl[k].dwd,
               tbl[k].caddr, tbl[k].crd, tbl[k].cwr, tbl[k].cwd);
         #4;
         check($sformatf("v%0d_mem_re", k), bus.mem_read_en, tbl[k].e_re);
         check($sformatf("v%0d_mem_we", k), bus.mem_write_en, tbl[k].e_we);
         if (tbl[k].e_re || tbl[k].e_we)
            check($sformatf("v%0d_mem_addr", k), bus.mem_addr, tbl[k].e_addr);
         if (tbl[k].e_we)
            check($sformatf("v%0d_mem_wdata", k), bus.mem_wdata, tbl[k].e_wd);
         if (tbl[k].crd)
            check($sformatf("v%0d_cpu_rdata", k), bus.cpu_rdata, tbl[k].e_crd);
         if (tbl[k].drd)
            check($sformatf("v%0d_dma_rdata", k), bus.dma_rdata, tbl[k].e_drd);
         tick();
      end
      check("tbl_cpu_blocked", cpu_blocked, 16'd5);
      check("tbl_oam_count", oam_count, 8'd1);
      check("tbl_dma_err", dma_err, 1'b0);

      // Full OAM transfer: read, write, idle per byte; scoreboard holds the byte read.
      done_cnt = 0;
      for (int i = 0; i < 160; i++) begin
         drive(1'b1, 16'(16'hC100 + i), 1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00);
         sb.push_back(pat(16'(16'hC100 + i)));
         #4;
         rd_byte = bus.dma_rdata;
         tick();
         done_cnt += int'(dma_done);
         drive(1'b1, 16'(16'hFE00 + i), 1'b0, 1'b1, rd_byte, 16'h0000, 1'b0, 1'b0, 8'h00);
         #4;
         exp_byte = sb.pop_front();
         check($sformatf("xfer%0d_wdata", i), bus.mem_wdata, exp_byte);
         if (i == 159) check("xfer_last_addr", bus.mem_addr, 16'hFE9F);
         tick();
         done_cnt += int'(dma_done);
         if (i == 159) check("done_after_last", dma_done, 1'b1);
         idle_inputs(1'b1);
         tick();
         done_cnt += int'(dma_done);
      end
      check("xfer_oam_count", oam_count, 8'd160);
      check("xfer_done_pulses", done_cnt, 1);
      check("xfer_dma_err", dma_err, 1'b0);
      check("xfer_oam_mem_last", mem[16'hFE9F], pat(16'hC19F));

      // 161st OAM byte saturates the count and flags an error.
      drive(1'b1, 16'hFE00, 1'b0, 1'b1, 8'hAA, 16'h0000, 1'b0, 1'b0, 8'h00);
      tick();
      check("oam_sat_count", oam_count, 8'd160);
      check("oam_sat_err", dma_err, 1'b1);
      check("oam_sat_done", dma_done, 1'b0);

      // DMA write outside OAM; error is sticky across idle and release.
      do_reset();
      drive(1'b1, 16'hC000, 1'b0, 1'b1, 8'h33, 16'h0000, 1'b0, 1'b0, 8'h00);
      tick();
      check("err_non_oam", dma_err, 1'b1);
      idle_inputs(1'b1);
      repeat (3) tick();
      idle_inputs(1'b0);
      repeat (3) tick();
      check("err_sticky", dma_err, 1'b1);

      // DMA request while idle is forwarded and flagged.
      do_reset();
      check("err_cleared_by_reset", dma_err, 1'b0);
      drive(1'b0, 16'hC000, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00);
      #4;
      check("idle_req_addr", bus.mem_addr, 16'hC000);
      check("idle_req_re", bus.mem_read_en, 1'b1);
      tick();
      check("err_idle_req", dma_err, 1'b1);

      // Reset while a posted write is pending: nothing must drain afterwards.
      do_reset();
      drive(1'b1, 16'hFE00, 1'b0, 1'b1, 8'h11, 16'hFF91, 1'b0, 1'b1, 8'hA5);
      tick();
      idle_inputs(1'b1);
      #1;
      check("pending_flush_visible", bus.mem_write_en, 1'b1);
      check("pending_oam_count", oam_count, 8'd1);
      reset = 1'b1;
      #1;
      check("midrst_mem_we", bus.mem_write_en, 1'b0);
      check("midrst_mem_re", bus.mem_read_en, 1'b0);
      check("midrst_oam_count", oam_count, 8'd0);
      check("midrst_dma_done", dma_done, 1'b0);
      check("midrst_dma_err", dma_err, 1'b0);
      check("midrst_cpu_blocked", cpu_blocked, 16'd0);
      tick();
      idle_inputs(1'b0);
      reset = 1'b0;
      #3;
      check("no_flush_we", bus.mem_write_en, 1'b0);
      tick();
      tick();
      check("no_flush_mem", mem[16'hFF91], 8'h52);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
